metaball_sched: RTL and testbench

METABALL_SCHED -- requirements
Module: metaball_sched

---
 rtl/lava_pkg.sv | 21 ++
 rtl/metaball_sched_contrib_sum.sv | 22 ++
 rtl/metaball_sched.sv | 172 +++++++++++++++++
 tb/tb_metaball_sched.sv | 248 ++++++++++++++++++++++++
 4 files changed

// File: rtl/lava_pkg.sv
// Shared scheduler types, the Q16.15 unit constant and the saturating adder
// used to accumulate metaball field contributions.
package lava_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_STROBE,
    ST_WAIT,
    ST_WRITE,
    ST_MOVE
  } sched_state_e;

  localparam logic [31:0] ONE = 32'h0000_8000;

  function automatic logic [31:0] sat_add32(input logic [31:0] a, input logic [31:0] b);
    logic [32:0] s;
    s = {1'b0, a} + {1'b0, b};
    return s[32] ? 32'hFFFF_FFFF : s[31:0];
  endfunction

endpackage

// File: rtl/metaball_sched_contrib_sum.sv
// Combinational unsigned saturating sum of N_BALLS packed 32-bit contributions.
module contrib_sum
  import lava_pkg::*;
#(
  parameter int N_BALLS = 4
) (
  input  logic [N_BALLS*32-1:0] contrib_i,
  output logic [31:0]           sum_o
);

  logic [31:0] acc;

  always_comb begin
    acc = '0;
    for (int i = 0; i < N_BALLS; i++) begin
      acc = sat_add32(acc, contrib_i[32*i +: 32]);
    end
  end

  assign sum_o = acc;

endmodule

// File: rtl/metaball_sched.sv
// Raster scheduler: strobes every metaball per pixel, sums contributions, writes the lit bit.
// Defining METABALL_SCHED_TIMEOUT_EN adds a WAIT timeout and a sticky err output.
module metaball_sched
  import lava_pkg::*;
#(
  parameter int          N_BALLS = 4,
  parameter int          DISP_W  = 32,
  parameter int          DISP_H  = 64,
  parameter logic [31:0] THRESH  = ONE
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             frame_tick,
  output logic                             px_stb,
  output logic [31:0]                      p_x,
  output logic [31:0]                      p_y,
  input  logic [N_BALLS-1:0]               vld,
  input  logic [N_BALLS*32-1:0]            contrib,
  output logic                             mov_en,
  output logic                             fb_we,
  output logic [$clog2(DISP_W*DISP_H)-1:0] fb_addr,
  output logic                             fb_data,
  output logic                             busy,
  output logic                             frame_done
`ifdef METABALL_SCHED_TIMEOUT_EN
  ,
  output logic                             err
`endif
);

  localparam int CW = (DISP_W > 1) ? $clog2(DISP_W) : 1;
  localparam int RW = (DISP_H > 1) ? $clog2(DISP_H) : 1;
  localparam int AW = $clog2(DISP_W*DISP_H);

  // IDLE: wait tick | STROBE: pulse px_stb | WAIT: collect vld | WRITE: fb write | MOVE: advance balls
  sched_state_e state_q, state_d;

  logic [CW-1:0]         col_q, col_d;
  logic [RW-1:0]         row_q, row_d;
  logic [AW-1:0]         addr_q, addr_d;
  logic [31:0]           sum_q, sum_d;
  logic                  guard_q;
  logic [N_BALLS*32-1:0] contrib_m;
  logic [31:0]           sum_w;
  logic                  vld_ok, accept, last_col, last_row;

  for (genvar g = 0; g < N_BALLS; g++) begin : g_mask
    assign contrib_m[32*g +: 32] = contrib[32*g +: 32] & {32{vld[g]}};
  end

  contrib_sum #(.N_BALLS(N_BALLS)) u_sum (
    .contrib_i (contrib_m),
    .sum_o     (sum_w)
  );

  assign vld_ok   = (&vld) && !guard_q;
  assign last_col = (col_q == CW'(DISP_W - 1));
  assign last_row = (row_q == RW'(DISP_H - 1));

`ifdef METABALL_SCHED_TIMEOUT_EN
  logic [6:0] tmo_q, tmo_d;
  logic       err_q, expired;

  assign expired = (state_q == ST_WAIT) && !vld_ok && (tmo_q == '0);
  assign accept  = (state_q == ST_WAIT) && (vld_ok || (tmo_q == '0));

  always_comb begin
    tmo_d = tmo_q;
    if (state_q == ST_STROBE) begin
      tmo_d = 7'd63;
    end else if ((state_q == ST_WAIT) && (tmo_q != '0)) begin
      tmo_d = tmo_q - 7'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      tmo_q <= '0;
      err_q <= 1'b0;
    end else begin
      tmo_q <= tmo_d;
      err_q <= err_q | expired;
    end
  end

  assign err = err_q;
`else
  assign accept = (state_q == ST_WAIT) && vld_ok;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:   if (frame_tick) state_d = ST_STROBE;
      ST_STROBE: state_d = ST_WAIT;
      ST_WAIT:   if (accept) state_d = ST_WRITE;
      ST_WRITE:  state_d = (last_col && last_row) ? ST_MOVE : ST_STROBE;
      ST_MOVE:   state_d = ST_IDLE;
      default:   state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    px_stb     = 1'b0;
    fb_we      = 1'b0;
    mov_en     = 1'b0;
    frame_done = 1'b0;
    case (state_q)
      ST_STROBE: px_stb = 1'b1;
      ST_WRITE:  fb_we  = 1'b1;
      ST_MOVE: begin
        mov_en     = 1'b1;
        frame_done = 1'b1;
      end
      default: ;
    endcase
  end

  always_comb begin
    col_d  = col_q;
    row_d  = row_q;
    addr_d = addr_q;
    sum_d  = sum_q;
    if ((state_q == ST_IDLE) && frame_tick) begin
      col_d  = '0;
      row_d  = '0;
      addr_d = '0;
    end
    if (accept) sum_d = sum_w;
    // The write address runs alongside col/row, so no row*DISP_W multiply is needed.
    if ((state_q == ST_WRITE) && !(last_col && last_row)) begin
      addr_d = addr_q + AW'(1);
      if (last_col) begin
        col_d = '0;
        row_d = row_q + RW'(1);
      end else begin
        col_d = col_q + CW'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      col_q   <= '0;
      row_q   <= '0;
      addr_q  <= '0;
      sum_q   <= '0;
      guard_q <= 1'b0;
    end else begin
      col_q   <= col_d;
      row_q   <= row_d;
      addr_q  <= addr_d;
      sum_q   <= sum_d;
      guard_q <= (state_q == ST_STROBE);
    end
  end

  assign busy    = (state_q != ST_IDLE);
  assign fb_data = fb_we && (sum_q >= THRESH);
  assign fb_addr = addr_q;
  assign p_x     = 32'(col_q) << 15;
  assign p_y     = 32'(row_q) << 15;

endmodule

// File: tb/tb_metaball_sched.sv
// Bench for metaball_sched: table-driven pixel vectors over a full frame with an fb_we
// scoreboard, plus reset, stale-vld, mid-frame tick/reset and optional timeout sequences.
module tb_metaball_sched;

  localparam int NB = 4;
  localparam int W  = 32;
  localparam int H  = 64;
  localparam int AW = 11;
  localparam logic [31:0] TH = 32'h0000_8000;

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic            frame_tick = 1'b0;
  logic            px_stb, mov_en, fb_we, fb_data, busy, frame_done;
  logic [31:0]     p_x, p_y;
  logic [NB-1:0]   vld = '0;
  logic [NB*32-1:0] contrib = '0;
  logic [AW-1:0]   fb_addr;
`ifdef METABALL_SCHED_TIMEOUT_EN
  logic            err;
`endif

  metaball_sched #(.N_BALLS(NB), .DISP_W(W), .DISP_H(H), .THRESH(TH)) dut (
    .clk        (clk),
    .rst        (rst),
    .frame_tick (frame_tick),
    .px_stb     (px_stb),
    .p_x        (p_x),
    .p_y        (p_y),
    .vld        (vld),
    .contrib    (contrib),
    .mov_en     (mov_en),
    .fb_we      (fb_we),
    .fb_addr    (fb_addr),
    .fb_data    (fb_data),
    .busy       (busy),
    .frame_done (frame_done)
`ifdef METABALL_SCHED_TIMEOUT_EN
    ,
    .err        (err)
`endif
  );

  always #5 clk = ~clk;

  longint cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [NB*32-1:0] c;
    int               d;
    bit               stale;
    bit               lit;
  } vec_t;

  typedef struct {
    int     addr;
    bit     lit;
    longint when;
  } exp_t;

  vec_t vt[8];
  exp_t sbq[$];
  int   n_cmp = 0;
  int   n_bad = 0;
  int   n_we  = 0;
  int   n_mov = 0;

  task automatic chk(input string name, input longint act, input longint exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin : mon
    exp_t e;
    if (!rst && fb_we) begin
      n_we++;
      chk("fb_we_expected", longint'(sbq.size() > 0), 1);
      if (sbq.size() > 0) begin
        e = sbq.pop_front();
        chk("fb_addr", fb_addr, e.addr);
        chk("fb_data", fb_data, e.lit);
        chk("latency", cyc, e.when);
      end
    end
    if (mov_en) begin
      n_mov++;
      chk("px_stb_with_mov_en", px_stb, 0);
      chk("frame_done_with_mov_en", frame_done, 1);
    end
  end

  // Waits for the pixel strobe, books the expected write, then plays the ball response.
  task automatic run_pixel(input int k, input vec_t v, output bit ok);
    int   n;
    exp_t e;
    n = 0;
    while (!px_stb && n < 40) begin
      @(negedge clk);
      n++;
    end
    ok = px_stb;
    chk("px_stb_seen", px_stb, 1);
    if (!ok) return;
    chk("p_x", p_x, (k % W) << 15);
    chk("p_y", p_y, (k / W) << 15);
    e.addr = k;
    e.lit  = v.lit;
    e.when = cyc + v.d + 1;
    sbq.push_back(e);
    if (!v.stale) begin
      vld     = '0;
      contrib = {NB{32'hDEAD_BEEF}};
    end
    if (k == 500) frame_tick = 1'b1;
    @(negedge clk);
    frame_tick = 1'b0;
    @(negedge clk);
    vld     = '0;
    contrib = {NB{32'hDEAD_BEEF}};
    repeat (v.d - 2) @(negedge clk);
    contrib = v.c;
    vld     = '1;
  endtask

  initial begin : wdog
    #1000000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1, "watchdog expired");
  end

  initial begin : main
    bit ok;
    int n;
    int mov0;
    exp_t e;

    vt[0] = '{c: {32'h0, 32'h0, 32'h0, 32'h0001_0000},                         d: 3, stale: 1'b0, lit: 1'b1};
    vt[1] = '{c: {32'h0, 32'h0, 32'h0000_3FFF, 32'h0000_3FFF},                 d: 2, stale: 1'b0, lit: 1'b0};
    vt[2] = '{c: {32'h0, 32'h0, 32'h0000_4000, 32'h0000_4000},                 d: 4, stale: 1'b0, lit: 1'b1};
    vt[3] = '{c: {32'hFFFF_0000, 32'hFFFF_0000, 32'hFFFF_0000, 32'hFFFF_0000}, d: 3, stale: 1'b0, lit: 1'b1};
    vt[4] = '{c: {32'h0, 32'h0, 32'h0, 32'h0000_7FFF},                         d: 5, stale: 1'b1, lit: 1'b0};
    vt[5] = '{c: {32'h0, 32'h0, 32'h0, 32'h0000_8000},                         d: 2, stale: 1'b0, lit: 1'b1};
    vt[6] = '{c: {32'h0, 32'h0, 32'h0, 32'h0},                                 d: 6, stale: 1'b0, lit: 1'b0};
    vt[7] = '{c: {32'h0000_1000, 32'h0000_1000, 32'h0000_2000, 32'h0000_4000}, d: 3, stale: 1'b1, lit: 1'b1};

    rst = 1'b1;
    repeat (3) @(negedge clk);
    chk("rst_px_stb", px_stb, 0);
    chk("rst_mov_en", mov_en, 0);
    chk("rst_fb_we", fb_we, 0);
    chk("rst_fb_data", fb_data, 0);
    chk("rst_frame_done", frame_done, 0);
    chk("rst_busy", busy, 0);
    chk("rst_p_x", p_x, 0);
    chk("rst_p_y", p_y, 0);
    chk("rst_fb_addr", fb_addr, 0);
`ifdef METABALL_SCHED_TIMEOUT_EN
    chk("rst_err", err, 0);
`endif
    rst = 1'b0;
    repeat (2) @(negedge clk);
    chk("idle_busy", busy, 0);

    // Full frame through the vector table.
    frame_tick = 1'b1;
    @(negedge clk);
    frame_tick = 1'b0;
    ok = 1'b1;
    for (int k = 0; k < W*H && ok; k++) run_pixel(k, vt[k % 8], ok);
    n = 0;
    while (!frame_done && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk("frame_done_seen", frame_done, 1);
    @(negedge clk);
    chk("frame1_busy_after", busy, 0);
    chk("frame1_we_count", n_we, W*H);
    chk("frame1_mov_count", n_mov, 1);
    chk("frame1_sb_empty", sbq.size(), 0);
    chk("frame1_last_addr", fb_addr, W*H - 1);

    // Second frame, reset at pixel 100.
    n_we = 0;
    mov0 = n_mov;
    frame_tick = 1'b1;
    @(negedge clk);
    frame_tick = 1'b0;
    ok = 1'b1;
    for (int k = 0; k < 100 && ok; k++) run_pixel(k, vt[k % 8], ok);
    n = 0;
    while (!px_stb && n < 40) begin
      @(negedge clk);
      n++;
    end
    chk("px100_stb", px_stb, 1);
    chk("px100_p_x", p_x, (100 % W) << 15);
    chk("px100_p_y", p_y, (100 / W) << 15);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("abort_busy", busy, 0);
    chk("abort_fb_addr", fb_addr, 0);
    chk("abort_p_x", p_x, 0);
    chk("abort_p_y", p_y, 0);
    vld = '1;
    repeat (40) @(negedge clk);
    chk("abort_we_count", n_we, 100);
    chk("abort_mov_count", n_mov, mov0);
    chk("abort_sb_empty", sbq.size(), 0);
    chk("abort_still_idle", busy, 0);

`ifdef METABALL_SCHED_TIMEOUT_EN
    vld = '0;
    frame_tick = 1'b1;
    @(negedge clk);
    frame_tick = 1'b0;
    chk("tmo_px_stb", px_stb, 1);
    e.addr = 0;
    e.lit  = 1'b0;
    e.when = cyc + 65;
    sbq.push_back(e);
    vld     = 4'b1101;
    contrib = {32'h0, 32'h0, 32'h0000_4000, 32'h0000_4000};
    n = 0;
    while (sbq.size() > 0 && n < 120) begin
      @(negedge clk);
      n++;
    end
    chk("tmo_sb_empty", sbq.size(), 0);
    chk("tmo_err", err, 1);
    repeat (3) @(negedge clk);
    chk("tmo_err_sticky", err, 1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("tmo_err_cleared", err, 0);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
